// File: rtl/iter_cla_adder.sv
// Multi-cycle carry-lookahead adder/subtractor.
// Resolves one SLICE-bit lookahead slice per clock and carries the slice
// carry-out to the next slice through a register. Valid/ready handshakes are
// used on both the operand side and the result side.
module iter_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("iter_cla_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_g, sl_p, sl_s;
    logic             sl_cout, sl_cmsb, cr;
    int unsigned      base;
    logic [WIDTH-1:0] acc_merged;
    logic             last_slice;

    assign last_slice = (cnt_q == CW'(NSLICE - 1));

    // Current slice: generate/propagate lookahead seeded by the registered carry,
    // merged into a copy of the accumulator.
    always_comb begin
        base = 32'(cnt_q) * SLICE;
        sl_a = op_a_q[base +: SLICE];
        sl_b = op_b_q[base +: SLICE];
        sl_g = sl_a & sl_b;
        sl_p = sl_a ^ sl_b;
        sl_s = '0;
        sl_cmsb = carry_q;
        cr = carry_q;
        for (int i = 0; i < int'(SLICE); i++) begin
            sl_s[i] = sl_p[i] ^ cr;
            if (i == int'(SLICE) - 1) begin
                sl_cmsb = cr;
            end
            cr = sl_g[i] | (sl_p[i] & cr);
        end
        sl_cout = cr;
        acc_merged = acc_q;
        acc_merged[base +: SLICE] = sl_s;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = rst_n;
                if (in_valid) begin
                    op_a_d  = a;
                    // Subtract is a + ~b + ~borrow_in.
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ^ carry_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = acc_merged;
                carry_d = sl_cout;
                if (last_slice) begin
                    sum_d   = acc_merged;
                    cout_d  = sl_cout;
                    ovf_d   = sl_cmsb ^ sl_cout;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_iter_cla_adder.sv
// Self-checking bench for iter_cla_adder: default 32/8 instance plus a
// single-slice 16/16 instance. Expected results go through a scoreboard queue.
module tb_iter_cla_adder;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, carry_in, sub, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         carry_out, overflow;

    logic         in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0]  a16, b16, sum16;
    logic         carry_out16, overflow16;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iter_cla_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    iter_cla_adder #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .carry_in(1'b0), .sub(1'b0),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .carry_out(carry_out16), .overflow(overflow16)
    );

    // Independent reference: wide add and sign-based overflow rule.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? ~ci : ci)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and push the expectation; in_valid drops after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic s, input exp_t e);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
        end
        a = x; b = y; carry_in = ci; sub = s; in_valid = 1'b1;
        q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare latency and result, then drain.
    task automatic receive(input string name, input int exp_lat);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: result with empty scoreboard", name);
            return;
        end
        e = q.pop_front();
        checks++;
        if ({sum, carry_out, overflow} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                     name, sum, carry_out, overflow, e.sum, e.cout, e.ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%0b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({out_valid, in_ready, sum, carry_out, overflow, out_valid16, in_ready16} !== '0) begin
            errors++;
            $display("FAIL reset_state: ov=%0b ir=%0b sum=%h co=%0b of=%0b ov16=%0b ir16=%0b required all 0",
                     out_valid, in_ready, sum, carry_out, overflow, out_valid16, in_ready16);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b/%0b required 1/1", in_ready, in_ready16);
        end
    endtask

    task automatic test_single_slice();
        int lat = 0;
        a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        while (!out_valid16 && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL single_latency: got %0d required 1", lat);
        end
        checks++;
        if ({sum16, carry_out16, overflow16} !== {16'hFFFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_result: sum=%h cout=%0b ovf=%0b required fffe 1 0",
                     sum16, carry_out16, overflow16);
        end
        out_ready16 = 1'b1;
        step();
        out_ready16 = 1'b0;
    endtask

    task automatic test_arith();
        // Carry ripples across every slice boundary.
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{sum: 32'h0, cout: 1'b1, ovf: 1'b0});
        receive("ripple", 4);
        send(32'h5, 32'h7, 1'b0, 1'b1, '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0});
        receive("sub_borrow", 4);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1});
        receive("sub_ovf", 4);
        send(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1});
        receive("add_ovf", 4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x, y;
            logic         ci, s;
            x  = $urandom;
            y  = $urandom;
            ci = 1'($urandom_range(1));
            s  = 1'(i % 2);
            send(x, y, ci, s, model(x, y, ci, s));
            receive("random", 4);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat = 0;
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0,
             model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0));
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        e = q[0];
        a = 32'hDEAD_BEEF; b = 32'h0000_0042; carry_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, sum, carry_out, overflow} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL hold_%0d: ov=%0b ir=%0b sum=%h co=%0b of=%0b required 1 0 %h %0b %0b",
                         i, out_valid, in_ready, sum, carry_out, overflow, e.sum, e.cout, e.ovf);
            end
            step();
        end
        void'(q.pop_front());
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
        end
        q.push_back(model(32'hDEAD_BEEF, 32'h0000_0042, 1'b0, 1'b1));
        step();
        in_valid = 1'b0;
        receive("after_bp", 4);
    endtask

    task automatic test_reset_mid_run();
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, '{sum: '0, cout: 1'b0, ovf: 1'b0});
        void'(q.pop_front());
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({out_valid, sum, in_ready} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: ov=%0b sum=%h ir=%0b required 0 0 0", out_valid, sum, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_idle: in_ready=%0b required 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b0 || sum !== '0) begin
                errors++;
                $display("FAIL midrun_stale_%0d: ov=%0b sum=%h required 0 0", i, out_valid, sum);
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        carry_in = 1'b0; sub = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        #1;
        test_reset();
        test_single_slice();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
